trig_job_sched: RTL and testbench
=================================

TRIG_JOB_SCHED -- requirements
Module: trig_job_sched

Interface
REQ-001 SHALL have parameter MAX_ANGLE, default 90, largest legal angle in degrees.
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum wait cycles on any done input.
REQ-003 SHALL have these ports: clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports req_valid  in  2  per-requester request; req_angle0, req_angle1  in  8  binary degrees; req_ready  out  2  one-cycle accept pulse.
REQ-005 SHALL have ports cordic_start  out  1  pulse; cordic_angle  out  12  angle<<4; cordic_done  in  1; cordic_cos, cordic_sin  in  12  binary magnitudes.
REQ-006 SHALL have ports bcd_rst  out  1; bcd_start  out  1; bcd_bin  out  10  converter operand; bcd_done  in  1; bcd_val  in  12  three BCD digits.
REQ-007 SHALL have ports rsp_valid  out  1; rsp_ready  in  1; rsp_id  out  1  requester index; rsp_cos, rsp_sin  out  12  BCD; rsp_err  out  1.
REQ-008 SHALL have port busy  out  1, high in every state except IDLE.

Function
REQ-009 SHALL use the states IDLE, CORDIC, BCD_COS, BCD_SIN, RESP, with one job in flight at a time.
REQ-010 In IDLE with any req_valid, SHALL grant round-robin: the requester not granted last wins a tie; a lone requester always wins.
REQ-011 On grant SHALL pulse req_ready[id] for one cycle, latch the angle and id, and update the last-grant pointer.
REQ-012 If the latched angle exceeds MAX_ANGLE, SHALL go directly to RESP with rsp_err=1 and rsp_cos=rsp_sin=0, and SHALL NOT start the core.
REQ-013 Otherwise SHALL drive cordic_angle={angle,4'b0000}, pulse cordic_start for exactly one cycle on CORDIC entry, and wait in CORDIC.
REQ-014 On cordic_done SHALL capture cordic_cos and cordic_sin and enter BCD_COS.
REQ-015 Each BCD state SHALL follow this sequence: bcd_rst high one cycle, then bcd_start high one cycle (bcd_rst low), then wait for bcd_done.
REQ-016 bcd_bin SHALL be captured cos[9:0] in BCD_COS and sin[9:0] in BCD_SIN, held stable for the whole state.
REQ-017 On bcd_done SHALL capture bcd_val into rsp_cos (BCD_COS, then go to BCD_SIN) or rsp_sin (BCD_SIN, then go to RESP).
REQ-018 done inputs arriving before the matching start pulse SHALL be ignored.
REQ-019 A per-state wait counter SHALL abort to RESP with rsp_err=1 and zeroed data when it reaches TIMEOUT cycles without the awaited done.
REQ-020 In RESP SHALL hold rsp_valid=1 with stable data until rsp_ready=1, then return to IDLE on the next cycle.
REQ-021 Grant-to-rsp_valid latency SHALL be 2 + t_cordic + 2*(2 + t_bcd) cycles, where t is the cycles from start pulse to done.
REQ-022 Requests arriving while busy SHALL remain pending; req_ready SHALL never pulse outside IDLE.
REQ-023 Back-to-back jobs SHALL issue their grant no earlier than the cycle after the RESP handshake.

Reset
REQ-024 reset SHALL force IDLE from any state, aborting an in-flight job with no response.
REQ-025 Reset values SHALL be: req_ready=0, cordic_start=0, bcd_rst=1, bcd_start=0, rsp_valid=0, rsp_err=0, rsp_id=0, busy=0, all data registers 0, last-grant pointer=1 (requester 0 wins first).

Structure
REQ-026 State encoding, MAX_ANGLE, TIMEOUT default and the angle<<4 scaling width SHALL live in a shared trig_pkg package.
REQ-027 The round-robin grant logic SHALL be a sub-module rr_arb2, combinational grant with a registered pointer.
REQ-028 The block SHALL contain no arithmetic beyond the comparison, shift, and counter.

Verification
REQ-029 Reset, req_valid=01, angle0=30, model CORDIC returns cos=520, sin=300; BCD model -> rsp_id=0, rsp_cos=12'h520, rsp_sin=12'h300, rsp_err=0.
REQ-030 req_valid=11 held for three jobs -> grant order 0,1,0, each req_ready a single-cycle pulse.
REQ-031 angle1=91 -> rsp_err=1, zero data, cordic_start never asserted.
REQ-032 cordic_done withheld -> rsp_err=1 after 255 wait cycles, then IDLE.
REQ-033 rsp_ready held low for 20 cycles -> rsp_valid and data stable; next grant waits for the handshake.
REQ-034 reset asserted during BCD_SIN -> next cycle IDLE, busy=0, rsp_valid=0, bcd_rst=1.

Source files
------------

// File: rtl/trig_pkg.sv
// Shared types and constants for the trig job scheduler: FSM encodings,
// angle range/timeout defaults and the CORDIC angle scaling.
package trig_pkg;

  localparam int unsigned ANGLE_W       = 8;
  localparam int unsigned ANGLE_SHIFT   = 4;
  localparam int unsigned CORDIC_W      = ANGLE_W + ANGLE_SHIFT;
  localparam int unsigned BCD_BIN_W     = 10;
  localparam int unsigned BCD_W         = 12;
  localparam int unsigned MAX_ANGLE_DEF = 90;
  localparam int unsigned TIMEOUT_DEF   = 255;

  typedef enum logic [2:0] {
    IDLE,
    CORDIC,
    BCD_COS,
    BCD_SIN,
    RESP
  } state_t;

  // Sub-step inside a core-driving state: entry cycle (cordic_start or
  // bcd_rst), bcd_start cycle, then waiting for done.
  typedef enum logic [1:0] {
    PH_ENTRY,
    PH_START,
    PH_WAIT
  } phase_t;

  function automatic logic [CORDIC_W-1:0] scale_angle(input logic [ANGLE_W-1:0] a);
    return {a, {ANGLE_SHIFT{1'b0}}};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: combinational grant, registered
// last-grant pointer (reset to 1 so requester 0 wins the first tie).
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       grant_id
);

  logic last;

  always_comb begin
    grant_id = 1'b0;
    if (req == 2'b11) begin
      grant_id = ~last;
    end else begin
      grant_id = req[1];
    end
    grant = {grant_id, ~grant_id} & {2{|req}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last <= 1'b1;
    end else if (advance) begin
      last <= grant_id;
    end
  end

endmodule

// File: rtl/trig_job_sched.sv
// Schedules one trig job at a time: arbitrates two requesters, runs the
// CORDIC core, converts cos/sin through the BCD converter and returns a response.
module trig_job_sched
  import trig_pkg::*;
#(
  parameter int unsigned MAX_ANGLE = MAX_ANGLE_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  input  logic [ANGLE_W-1:0]   req_angle0,
  input  logic [ANGLE_W-1:0]   req_angle1,
  output logic [1:0]           req_ready,
  output logic                 cordic_start,
  output logic [CORDIC_W-1:0]  cordic_angle,
  input  logic                 cordic_done,
  input  logic [CORDIC_W-1:0]  cordic_cos,
  input  logic [CORDIC_W-1:0]  cordic_sin,
  output logic                 bcd_rst,
  output logic                 bcd_start,
  output logic [BCD_BIN_W-1:0] bcd_bin,
  input  logic                 bcd_done,
  input  logic [BCD_W-1:0]     bcd_val,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [BCD_W-1:0]     rsp_cos,
  output logic [BCD_W-1:0]     rsp_sin,
  output logic                 rsp_err,
  output logic                 busy
);

  localparam int unsigned         CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]    TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ANGLE_W-1:0]  MAX_A    = ANGLE_W'(MAX_ANGLE);

  state_t state, state_nxt;
  phase_t phase, phase_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic [ANGLE_W-1:0]   angle_r;
  logic                 id_r;
  logic [BCD_BIN_W-1:0] cos_r, sin_r;

  logic [1:0]         grant;
  logic               grant_id;
  logic               grant_take;
  logic               range_err;
  logic               cap_cordic;
  logic               cap_bcd;
  logic               abort;
  logic               done_sel;
  logic [ANGLE_W-1:0] sel_angle;
  logic               unused_msb;

  // Only the low 10 bits of each magnitude feed the BCD converter.
  assign unused_msb = ^{cordic_cos[CORDIC_W-1:BCD_BIN_W], cordic_sin[CORDIC_W-1:BCD_BIN_W]};

  rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      (req_valid),
    .advance  (grant_take),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign sel_angle = grant_id ? req_angle1 : req_angle0;
  assign done_sel  = (state == CORDIC) ? cordic_done : bcd_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      phase <= PH_ENTRY;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    phase_nxt  = phase;
    cnt_nxt    = cnt;
    grant_take = 1'b0;
    range_err  = 1'b0;
    cap_cordic = 1'b0;
    cap_bcd    = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          grant_take = 1'b1;
          phase_nxt  = PH_ENTRY;
          cnt_nxt    = '0;
          if (sel_angle > MAX_A) begin
            range_err = 1'b1;
            state_nxt = RESP;
          end else begin
            state_nxt = CORDIC;
          end
        end
      end
      CORDIC, BCD_COS, BCD_SIN: begin
        case (phase)
          PH_ENTRY: phase_nxt = (state == CORDIC) ? PH_WAIT : PH_START;
          PH_START: phase_nxt = PH_WAIT;
          default: begin
            // Done is only honoured in the wait phase, after the start pulse.
            if (done_sel) begin
              phase_nxt = PH_ENTRY;
              cnt_nxt   = '0;
              if (state == CORDIC) begin
                cap_cordic = 1'b1;
                state_nxt  = BCD_COS;
              end else begin
                cap_bcd   = 1'b1;
                state_nxt = (state == BCD_COS) ? BCD_SIN : RESP;
              end
            end else if (cnt == TMO_LAST) begin
              abort     = 1'b1;
              state_nxt = RESP;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        endcase
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      angle_r <= '0;
      id_r    <= 1'b0;
      cos_r   <= '0;
      sin_r   <= '0;
      rsp_cos <= '0;
      rsp_sin <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (grant_take) begin
        angle_r <= sel_angle;
        id_r    <= grant_id;
        rsp_err <= range_err;
        rsp_cos <= '0;
        rsp_sin <= '0;
      end
      if (cap_cordic) begin
        cos_r <= cordic_cos[BCD_BIN_W-1:0];
        sin_r <= cordic_sin[BCD_BIN_W-1:0];
      end
      if (cap_bcd) begin
        if (state == BCD_COS) begin
          rsp_cos <= bcd_val;
        end else begin
          rsp_sin <= bcd_val;
        end
      end
      if (abort) begin
        rsp_err <= 1'b1;
        rsp_cos <= '0;
        rsp_sin <= '0;
      end
    end
  end

  always_comb begin
    req_ready    = (state == IDLE && !reset) ? grant : '0;
    cordic_start = (state == CORDIC) && (phase == PH_ENTRY);
    cordic_angle = scale_angle(angle_r);
    bcd_rst      = !(((state == BCD_COS) || (state == BCD_SIN)) && (phase != PH_ENTRY));
    bcd_start    = ((state == BCD_COS) || (state == BCD_SIN)) && (phase == PH_START);
    bcd_bin      = (state == BCD_SIN) ? sin_r : cos_r;
    rsp_valid    = (state == RESP);
    rsp_id       = id_r;
    busy         = (state != IDLE);
  end

endmodule

// File: tb/tb_trig_job_sched.sv
// Directed bench for trig_job_sched with behavioural CORDIC and BCD core models.
module tb_trig_job_sched;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [7:0]  req_angle0, req_angle1;
  logic [1:0]  req_ready;
  logic        cordic_start;
  logic [11:0] cordic_angle;
  logic        cordic_done;
  logic [11:0] cordic_cos, cordic_sin;
  logic        bcd_rst, bcd_start;
  logic [9:0]  bcd_bin;
  logic        bcd_done;
  logic [11:0] bcd_val;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [11:0] rsp_cos, rsp_sin;

  int n_chk = 0;
  int n_err = 0;
  int cstarts = 0;

  int unsigned t_cordic = 3;
  int unsigned t_bcd    = 2;
  bit          cordic_en = 1'b1;
  logic [11:0] cos_m = 12'd520;
  logic [11:0] sin_m = 12'd300;

  trig_job_sched #(.MAX_ANGLE(90), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_angle0(req_angle0), .req_angle1(req_angle1),
    .req_ready(req_ready),
    .cordic_start(cordic_start), .cordic_angle(cordic_angle), .cordic_done(cordic_done),
    .cordic_cos(cordic_cos), .cordic_sin(cordic_sin),
    .bcd_rst(bcd_rst), .bcd_start(bcd_start), .bcd_bin(bcd_bin),
    .bcd_done(bcd_done), .bcd_val(bcd_val),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_cos(rsp_cos), .rsp_sin(rsp_sin), .rsp_err(rsp_err), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) if (cordic_start) cstarts <= cstarts + 1;

  function automatic logic [11:0] to_bcd(input logic [9:0] b);
    int v;
    v = int'(b);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // CORDIC model: done one cycle, t_cordic cycles after the start pulse.
  initial begin
    cordic_done = 1'b0;
    cordic_cos  = '0;
    cordic_sin  = '0;
    forever begin
      @(negedge clk);
      cordic_done = 1'b0;
      if (cordic_start && cordic_en) begin
        repeat (t_cordic) @(negedge clk);
        cordic_cos  = cos_m;
        cordic_sin  = sin_m;
        cordic_done = 1'b1;
      end
    end
  end

  initial begin
    bcd_done = 1'b0;
    bcd_val  = '0;
    forever begin
      @(negedge clk);
      bcd_done = 1'b0;
      if (bcd_start) begin
        repeat (t_bcd) @(negedge clk);
        bcd_val  = to_bcd(bcd_bin);
        bcd_done = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after a negedge; returns just after the negedge of the
  // first IDLE cycle following the response handshake.
  task automatic do_job(input logic [1:0] rv, input logic [7:0] a0, input logic [7:0] a1,
                        input logic [1:0] exp_rdy, input logic [11:0] exp_ang, input int exp_lat,
                        input logic exp_id, input logic [11:0] exp_cos, input logic [11:0] exp_sin,
                        input logic exp_err, input int hold, input bit keep);
    int n;
    int lat;
    int s0;
    bit stable;
    req_valid  = rv;
    req_angle0 = a0;
    req_angle1 = a1;
    #1;
    n = 0;
    while (req_ready == 2'b00 && n < 400) begin
      @(negedge clk); #1; n++;
    end
    chk("grant", 32'(req_ready), 32'(exp_rdy));
    s0 = cstarts;
    @(negedge clk);
    if (!keep) req_valid = 2'b00;
    #1;
    chk("ready_pulse", 32'(req_ready), 32'd0);
    chk("busy", 32'(busy), 32'd1);
    chk("cordic_start", 32'(cordic_start), (exp_ang != 12'd0) ? 32'd1 : 32'd0);
    if (exp_ang != 12'd0) chk("cordic_angle", 32'(cordic_angle), 32'(exp_ang));
    lat = 1;
    while (!rsp_valid && lat < 600) begin
      @(negedge clk); #1; lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("rsp_id", 32'(rsp_id), 32'(exp_id));
    chk("rsp_cos", 32'(rsp_cos), 32'(exp_cos));
    chk("rsp_sin", 32'(rsp_sin), 32'(exp_sin));
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    chk("start_count", 32'(cstarts - s0), (exp_ang != 12'd0) ? 32'd1 : 32'd0);
    stable = 1'b1;
    repeat (hold) begin
      @(negedge clk); #1;
      if (!rsp_valid || rsp_cos !== exp_cos || rsp_sin !== exp_sin ||
          rsp_err !== exp_err || rsp_id !== exp_id || req_ready !== 2'b00) stable = 1'b0;
    end
    if (hold > 0) chk("hold_stable", 32'(stable), 32'd1);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("idle_after", 32'(busy), 32'd0);
    chk("rsp_drop", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 2'b00;
    req_angle0 = '0;
    req_angle1 = '0;
    rsp_ready  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_cordic_start", 32'(cordic_start), 32'd0);
    chk("rst_bcd_rst", 32'(bcd_rst), 32'd1);
    chk("rst_bcd_start", 32'(bcd_start), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'({rsp_cos, rsp_sin}), 32'd0);
    chk("rst_angle", 32'(cordic_angle), 32'd0);
    req_valid = 2'b01;
    #1;
    chk("rst_no_grant", 32'(req_ready), 32'd0);
    @(negedge clk);
    req_valid = 2'b00;
    reset     = 1'b0;
    @(negedge clk);

    // Basic job: 2 + 3 + 2*(2+2) = 13
    do_job(2'b01, 8'd30, 8'd0, 2'b01, 12'h1E0, 13, 1'b0, 12'h520, 12'h300, 1'b0, 0, 1'b0);

    // Out-of-range angle on requester 1
    do_job(2'b10, 8'd0, 8'd91, 2'b10, 12'h000, 1, 1'b1, 12'h000, 12'h000, 1'b1, 0, 1'b0);

    // Both requesting: 0,1,0; 2 + 5 + 2*(2+4) = 19
    t_cordic = 5;
    t_bcd    = 4;
    cos_m    = 12'd866;
    sin_m    = 12'd500;
    do_job(2'b11, 8'd45, 8'd60, 2'b01, 12'h2D0, 19, 1'b0, 12'h866, 12'h500, 1'b0, 0, 1'b1);
    do_job(2'b11, 8'd45, 8'd60, 2'b10, 12'h3C0, 19, 1'b1, 12'h866, 12'h500, 1'b0, 0, 1'b1);
    do_job(2'b11, 8'd45, 8'd60, 2'b01, 12'h2D0, 19, 1'b0, 12'h866, 12'h500, 1'b0, 0, 1'b0);

    // Response held 20 cycles with both still requesting; 2 + 1 + 2*3 = 9
    t_cordic = 1;
    t_bcd    = 1;
    do_job(2'b11, 8'd45, 8'd60, 2'b10, 12'h3C0, 9, 1'b1, 12'h866, 12'h500, 1'b0, 20, 1'b1);

    // CORDIC never answers: 255 wait cycles after the start cycle
    cordic_en = 1'b0;
    do_job(2'b01, 8'd10, 8'd60, 2'b01, 12'h0A0, 257, 1'b0, 12'h000, 12'h000, 1'b1, 0, 1'b0);
    cordic_en = 1'b1;

    // Reset while in BCD_SIN (its bcd_start cycle is grant + 17)
    t_cordic   = 2;
    t_bcd      = 10;
    req_valid  = 2'b10;
    req_angle1 = 8'd20;
    #1;
    chk("abort_grant", 32'(req_ready), 32'd2);
    @(negedge clk);
    req_valid = 2'b00;
    repeat (16) @(negedge clk);
    #1;
    chk("in_bcd_sin_start", 32'(bcd_start), 32'd1);
    chk("in_bcd_sin_bin", 32'(bcd_bin), 32'd500);
    chk("in_bcd_sin_rst", 32'(bcd_rst), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_bcd_rst", 32'(bcd_rst), 32'd1);
    chk("abort_bcd_start", 32'(bcd_start), 32'd0);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    #1;
    chk("abort_no_rsp", 32'({busy, rsp_valid}), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
